// File: rtl/fu_writeback_arbiter.sv
// Write-back arbiter for the execution stage.
// Each functional unit (0 = LSU, 1 = FPU, 2 = INT, 3 = BRANCH) pushes its
// results into a private FIFO. Up to two FIFO heads per cycle are granted
// round-robin onto two registered write-back ports toward the ROB/RF.
// fu_ready is derived from registered FIFO occupancy only, so an FU never
// sees a combinational path from this cycle's grants.
module fu_writeback_arbiter #(
  parameter int FU_NUMBER      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int R_ADDR         = 6,
  parameter int ROB_INDEX_BITS = 3,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic [FU_NUMBER-1:0]                  fu_valid,
  input  logic [FU_NUMBER*R_ADDR-1:0]           fu_dest,
  input  logic [FU_NUMBER*DATA_WIDTH-1:0]       fu_data,
  input  logic [FU_NUMBER*ROB_INDEX_BITS-1:0]   fu_ticket,
  output logic [FU_NUMBER-1:0]                  fu_ready,
  output logic [1:0]                            wb_valid,
  output logic [2*R_ADDR-1:0]                   wb_dest,
  output logic [2*DATA_WIDTH-1:0]               wb_data,
  output logic [2*ROB_INDEX_BITS-1:0]           wb_ticket,
  output logic [2*$clog2(FU_NUMBER)-1:0]        wb_fu
);

  localparam int FU_W  = $clog2(FU_NUMBER);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [R_ADDR-1:0]         dest_mem [FU_NUMBER][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem [FU_NUMBER][FIFO_DEPTH];
  logic [ROB_INDEX_BITS-1:0] tkt_mem  [FU_NUMBER][FIFO_DEPTH];

  logic [CNT_W-1:0] count  [FU_NUMBER];
  logic [PTR_W-1:0] rd_ptr [FU_NUMBER];
  logic [PTR_W-1:0] wr_ptr [FU_NUMBER];

  logic [FU_W-1:0]      rr_ptr;
  logic [FU_W-1:0]      g0_idx;
  logic [FU_W-1:0]      g1_idx;
  logic                 g0_vld;
  logic                 g1_vld;
  logic [FU_NUMBER-1:0] push;
  logic [FU_NUMBER-1:0] pop;

  function automatic logic [FU_W-1:0] next_idx(input logic [FU_W-1:0] g);
    return (g == FU_W'(FU_NUMBER - 1)) ? '0 : g + FU_W'(1);
  endfunction

  // Ready from registered occupancy; accept a push only when ready and not flushing.
  always_comb begin
    fu_ready = '0;
    push     = '0;
    for (int i = 0; i < FU_NUMBER; i++) begin
      fu_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH));
      push[i]     = fu_valid[i] & fu_ready[i] & ~flush;
    end
  end

  // Round-robin scan from rr_ptr: first non-empty FIFO to port 0, second to port 1.
  always_comb begin
    int j;
    j      = 0;
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_idx = '0;
    g1_idx = '0;
    pop    = '0;
    for (int k = 0; k < FU_NUMBER; k++) begin
      j = (int'(rr_ptr) + k) % FU_NUMBER;
      if (count[j] != '0) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = FU_W'(j);
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = FU_W'(j);
        end
      end
    end
    if (g0_vld) pop[g0_idx] = 1'b1;
    if (g1_vld) pop[g1_idx] = 1'b1;
  end

  // FIFO payload storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_NUMBER; i++) begin
      if (push[i]) begin
        dest_mem[i][wr_ptr[i]] <= fu_dest[i*R_ADDR +: R_ADDR];
        data_mem[i][wr_ptr[i]] <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
        tkt_mem[i][wr_ptr[i]]  <= fu_ticket[i*ROB_INDEX_BITS +: ROB_INDEX_BITS];
      end
    end
  end

  // FIFO pointers, occupancy and round-robin pointer; flush empties everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FU_NUMBER; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < FU_NUMBER; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < FU_NUMBER; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
        else if (!push[i] && pop[i]) count[i] <= count[i] - CNT_W'(1);
      end
      if (g1_vld)      rr_ptr <= next_idx(g1_idx);
      else if (g0_vld) rr_ptr <= next_idx(g0_idx);
    end
  end

  // Register granted heads onto the write-back ports (one-cycle valid pulse).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid  <= '0;
      wb_dest   <= '0;
      wb_data   <= '0;
      wb_ticket <= '0;
      wb_fu     <= '0;
    end else if (flush) begin
      wb_valid <= '0;
    end else begin
      wb_valid <= {g1_vld, g0_vld};
      if (g0_vld) begin
        wb_dest[0 +: R_ADDR]              <= dest_mem[g0_idx][rd_ptr[g0_idx]];
        wb_data[0 +: DATA_WIDTH]          <= data_mem[g0_idx][rd_ptr[g0_idx]];
        wb_ticket[0 +: ROB_INDEX_BITS]    <= tkt_mem[g0_idx][rd_ptr[g0_idx]];
        wb_fu[0 +: FU_W]                  <= g0_idx;
      end
      if (g1_vld) begin
        wb_dest[R_ADDR +: R_ADDR]                 <= dest_mem[g1_idx][rd_ptr[g1_idx]];
        wb_data[DATA_WIDTH +: DATA_WIDTH]         <= data_mem[g1_idx][rd_ptr[g1_idx]];
        wb_ticket[ROB_INDEX_BITS +: ROB_INDEX_BITS] <= tkt_mem[g1_idx][rd_ptr[g1_idx]];
        wb_fu[FU_W +: FU_W]                       <= g1_idx;
      end
    end
  end

endmodule
